arbiter_rr_1hot_8: RTL and testbench

Eight-requester round-robin arbiter producing a registered one-hot grant vector with hold and timeout. Sits directly upstream of the 8-to-3 one-hot encoder: `grant` feeds the encoder input, and `grant_valid` qualifies the encoder output. It guarantees the encoder only ever sees a legal one-hot word or all-zero.

---
 rtl/arb_pkg.sv | 7 +
 rtl/arbiter_rr_1hot_8_if.sv | 10 +
 rtl/rr_pick_8.sv | 20 ++
 rtl/arbiter_rr_1hot_8.sv | 64 ++++++
 tb/tb_arbiter_rr_1hot_8.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared widths and FSM state type for the round-robin one-hot arbiter
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int HOLD_W = 8;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/arbiter_rr_1hot_8_if.sv
// arbiter_rr_1hot_8_if: request/grant bundle between requesters and the arbiter
interface arbiter_rr_1hot_8_if;
  import arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic grant_valid;
  logic busy;
  modport master (output req, input grant, grant_valid, busy);
  modport slave (input req, output grant, grant_valid, busy);
endinterface

// File: rtl/rr_pick_8.sv
// rr_pick_8: combinational round-robin pick of the first request at or after ptr
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
  end
  assign pick_idx = ptr + off;
  assign pick_any = |req;
endmodule

// File: rtl/arbiter_rr_1hot_8.sv
// arbiter_rr_1hot_8: round-robin arbiter with registered one-hot grant, hold timeout and release bubble
module arbiter_rr_1hot_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst_n,
  arbiter_rr_1hot_8_if.slave bus
);
  localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic pick_any, release_now;
  rr_pick_8 u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );
  // grant only ever moves through IDLE, so the encoder never sees two one-hot words back-to-back
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    hold_cnt_d = hold_cnt_q;
    grant_d = grant_q;
    release_now = !bus.req[owner_q] || (MAX_HOLD != 0 && hold_cnt_q == MAX_H);
    if (state_q == IDLE) begin
      if (pick_any) begin
        grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
        owner_d = pick_idx;
        hold_cnt_d = HOLD_W'(1);
        state_d = GRANT;
      end
    end else if (release_now) begin
      grant_d = '0;
      ptr_d = owner_q + IDX_W'(1);
      state_d = IDLE;
    end else begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(~&hold_cnt_q);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      hold_cnt_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q <= grant_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.grant_valid = state_q == GRANT;
  assign bus.busy = state_q == GRANT;
endmodule

// File: tb/tb_arbiter_rr_1hot_8.sv
// tb_arbiter_rr_1hot_8: directed checks of reset, rotation, wrap, timeout and bubble behaviour
module tb_arbiter_rr_1hot_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  arbiter_rr_1hot_8_if ifa ();
  arbiter_rr_1hot_8_if ifb ();
  arbiter_rr_1hot_8_if ifc ();
  arbiter_rr_1hot_8 #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  arbiter_rr_1hot_8 #(.MAX_HOLD(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  arbiter_rr_1hot_8 #(.MAX_HOLD(4))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  always #5 clk = ~clk;

  function automatic logic [2:0] enc8to3(input logic [7:0] g);
    enc8to3 = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) enc8to3 = 3'(i);
  endfunction

  task automatic test_reset();
    ifa.req = 8'hFF;
    ifb.req = 8'h00;
    ifc.req = 8'h00;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: grant=%h gv=%b, want 00/0", i, ifa.grant, ifa.grant_valid);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h01 || ifa.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%h gv=%b, want 01/1", ifa.grant, ifa.grant_valid);
    end
    checks++;
    if (ifb.grant !== 8'h00 || ifc.grant !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle_others: b=%h c=%h, want 00/00", ifb.grant, ifc.grant);
    end
    ifa.req = 8'h00;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h00) begin
      errors++;
      $display("FAIL reset_drop: grant=%h, want 00", ifa.grant);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    ifa.req = 8'h10;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.grant !== 8'h10 || ifa.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cyc%0d: grant=%h busy=%b, want 10/1", i, ifa.grant, ifa.busy);
      end
    end
    ifa.req = 8'h00;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%h gv=%b busy=%b, want 00/0/0", ifa.grant, ifa.grant_valid, ifa.busy);
    end
  endtask

  task automatic test_wrap();
    ifa.req = 8'h30;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h20) begin
      errors++;
      $display("FAIL ptr_is_5: grant=%h, want 20", ifa.grant);
    end
    ifa.req = 8'h03;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h00) begin
      errors++;
      $display("FAIL wrap_bubble1: grant=%h, want 00", ifa.grant);
    end
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h01) begin
      errors++;
      $display("FAIL wrap_first: grant=%h, want 01", ifa.grant);
    end
    ifa.req = 8'h02;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h00) begin
      errors++;
      $display("FAIL wrap_bubble2: grant=%h, want 00", ifa.grant);
    end
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h02) begin
      errors++;
      $display("FAIL wrap_second: grant=%h, want 02", ifa.grant);
    end
    ifa.req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    ifa.req = 8'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.grant !== 8'h20 || ifa.grant_valid !== 1'b1 || enc8to3(ifa.grant) !== 3'b101) begin
        errors++;
        $display("FAIL enc_cosim cyc%0d: grant=%h gv=%b enc=%b, want 20/1/101", i, ifa.grant, ifa.grant_valid, enc8to3(ifa.grant));
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear: grant=%h gv=%b busy=%b, want 00/0/0", ifa.grant, ifa.grant_valid, ifa.busy);
    end
    rst_n = 1'b1;
    ifa.req = 8'hFF;
    @(negedge clk);
    checks++;
    if (ifa.grant !== 8'h01) begin
      errors++;
      $display("FAIL mid_reset_ptr: grant=%h, want 01", ifa.grant);
    end
    ifa.req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    ifb.req = 8'hFF;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      exp = ((k - 1) % 3 < 2) ? 8'(1 << (((k - 1) / 3) % 8)) : 8'h00;
      checks++;
      if (ifb.grant !== exp || ifb.grant_valid !== (exp != 8'h00) || !$onehot0(ifb.grant)) begin
        errors++;
        $display("FAIL rotation cyc%0d: grant=%h gv=%b, want %h/%b", k, ifb.grant, ifb.grant_valid, exp, exp != 8'h00);
      end
    end
    ifb.req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    ifc.req = 8'h08;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.grant !== ((i == 5) ? 8'h00 : 8'h08)) begin
        errors++;
        $display("FAIL timeout cyc%0d: grant=%h, want %h", i, ifc.grant, (i == 5) ? 8'h00 : 8'h08);
      end
    end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.grant !== 8'h08) begin
        errors++;
        $display("FAIL drop_hold cyc%0d: grant=%h, want 08", i, ifc.grant);
      end
    end
    ifc.req = 8'h00;
    @(negedge clk);
    checks++;
    if (ifc.grant !== 8'h00) begin
      errors++;
      $display("FAIL drop_timeout_bubble: grant=%h, want 00", ifc.grant);
    end
    ifc.req = 8'h18;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.grant !== 8'h10) begin
        errors++;
        $display("FAIL drop_timeout_ptr cyc%0d: grant=%h, want 10", i, ifc.grant);
      end
    end
    ifc.req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_mid_reset();
    test_rotation();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
